// File: rtl/osd_regaccess_pkg.sv
// Shared constants and types for the debug-ring register-access endpoint:
// packet header fields, subtypes, built-in addresses and FSM states.
package osd_regaccess_pkg;

    localparam logic [1:0] TYPE_REG = 2'b00;

    localparam logic [3:0] SUB_REQ_READ       = 4'd0;
    localparam logic [3:0] SUB_REQ_WRITE      = 4'd1;
    localparam logic [3:0] SUB_RESP_READ_OK   = 4'd8;
    localparam logic [3:0] SUB_RESP_READ_ERR  = 4'd9;
    localparam logic [3:0] SUB_RESP_WRITE_OK  = 4'd10;
    localparam logic [3:0] SUB_RESP_WRITE_ERR = 4'd11;

    localparam int HDR_TYPE_MSB = 15;
    localparam int HDR_TYPE_LSB = 14;
    localparam int HDR_SUB_MSB  = 13;
    localparam int HDR_SUB_LSB  = 10;

    localparam logic [15:0] ADDR_MOD_ID      = 16'h0000;
    localparam logic [15:0] ADDR_MOD_VERSION = 16'h0001;
    localparam logic [15:0] ADDR_MOD_VENDOR  = 16'h0002;
    localparam logic [15:0] ADDR_FIRST_FWD   = 16'h0200;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RX_SRC   = 4'd1,
        ST_RX_HDR   = 4'd2,
        ST_RX_ADDR  = 4'd3,
        ST_RX_WDATA = 4'd4,
        ST_ACCESS   = 4'd5,
        ST_TX_DEST  = 4'd6,
        ST_TX_SRC   = 4'd7,
        ST_TX_HDR   = 4'd8,
        ST_TX_DATA  = 4'd9,
        ST_DROP     = 4'd10
    } state_t;

    function automatic logic [15:0] resp_header(input logic [3:0] sub);
        return {TYPE_REG, sub, 10'b0};
    endfunction

endpackage

// File: rtl/osd_regaccess_endpoint.sv
// Debug-ring register-access endpoint: parses REG requests, serves the ID
// registers locally, forwards higher addresses to the host bus with a timeout.
module osd_regaccess_endpoint
    import osd_regaccess_pkg::*;
#(
    parameter logic [15:0] MOD_ID      = 16'h0000,
    parameter logic [15:0] MOD_VERSION = 16'h0000,
    parameter logic [15:0] MOD_VENDOR  = 16'h0001,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  id,
    input  logic [15:0] debug_in_data,
    input  logic        debug_in_valid,
    input  logic        debug_in_first,
    input  logic        debug_in_last,
    output logic        debug_in_ready,
    output logic [15:0] debug_out_data,
    output logic        debug_out_valid,
    output logic        debug_out_first,
    output logic        debug_out_last,
    input  logic        debug_out_ready,
    output logic        reg_request,
    output logic        reg_write,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    input  logic        reg_ack,
    input  logic        reg_err,
    input  logic [15:0] reg_rdata,
    output logic [3:0]  dbg_state
);

    // Valid/ready: a word moves on a clk edge where valid and ready are both
    // high; the sender keeps data/first/last steady while valid && !ready.

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [9:0]  src_q;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic        is_write_q;
    logic [3:0]  resp_sub_q;
    logic [9:0]  tmo_cnt;

    logic        in_xfer, hdr_ok, fwd, builtin, tmo_hit;
    logic [1:0]  in_type;
    logic [3:0]  in_sub;
    logic        load_src, load_hdr, load_addr, load_wdata, access_done;
    logic [3:0]  resp_sub_d;
    logic [15:0] rdata_d, builtin_val;

    assign in_xfer = debug_in_valid & debug_in_ready;
    assign in_type = debug_in_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign in_sub  = debug_in_data[HDR_SUB_MSB:HDR_SUB_LSB];
    assign hdr_ok  = (in_type == TYPE_REG) &&
                     (in_sub == SUB_REQ_READ || in_sub == SUB_REQ_WRITE);
    assign fwd     = (addr_q >= ADDR_FIRST_FWD);
    assign builtin = (addr_q <= ADDR_MOD_VENDOR);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_comb begin
        builtin_val = 16'h0000;
        case (addr_q)
            ADDR_MOD_ID:      builtin_val = MOD_ID;
            ADDR_MOD_VERSION: builtin_val = MOD_VERSION;
            ADDR_MOD_VENDOR:  builtin_val = MOD_VENDOR;
            default:          builtin_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_src    = 1'b0;
        load_hdr    = 1'b0;
        load_addr   = 1'b0;
        load_wdata  = 1'b0;
        access_done = 1'b0;
        resp_sub_d  = is_write_q ? SUB_RESP_WRITE_ERR : SUB_RESP_READ_ERR;
        rdata_d     = rdata_q;
        case (state)
            ST_IDLE: begin
                // Non-first words are swallowed; a single-word packet is too short.
                if (in_xfer && debug_in_first && !debug_in_last)
                    state_next = (debug_in_data[9:0] == id) ? ST_RX_SRC : ST_DROP;
            end
            ST_RX_SRC: begin
                if (in_xfer) begin
                    load_src   = 1'b1;
                    state_next = debug_in_last ? ST_IDLE : ST_RX_HDR;
                end
            end
            ST_RX_HDR: begin
                if (in_xfer) begin
                    load_hdr = 1'b1;
                    if (debug_in_last) state_next = ST_IDLE;
                    else if (!hdr_ok)  state_next = ST_DROP;
                    else               state_next = ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: begin
                if (in_xfer) begin
                    load_addr = 1'b1;
                    if (is_write_q) state_next = debug_in_last ? ST_IDLE : ST_RX_WDATA;
                    else            state_next = debug_in_last ? ST_ACCESS : ST_DROP;
                end
            end
            ST_RX_WDATA: begin
                if (in_xfer) begin
                    load_wdata = 1'b1;
                    state_next = debug_in_last ? ST_ACCESS : ST_DROP;
                end
            end
            ST_ACCESS: begin
                if (fwd) begin
                    // Error beats ack when both arrive; timeout only if neither did.
                    if (reg_err) begin
                        access_done = 1'b1;
                    end else if (reg_ack) begin
                        access_done = 1'b1;
                        resp_sub_d  = is_write_q ? SUB_RESP_WRITE_OK : SUB_RESP_READ_OK;
                        rdata_d     = reg_rdata;
                    end else if (tmo_hit) begin
                        access_done = 1'b1;
                    end
                end else if (builtin && !is_write_q) begin
                    access_done = 1'b1;
                    resp_sub_d  = SUB_RESP_READ_OK;
                    rdata_d     = builtin_val;
                end else begin
                    access_done = 1'b1;
                end
                if (access_done) state_next = ST_TX_DEST;
            end
            ST_TX_DEST: if (debug_out_ready) state_next = ST_TX_SRC;
            ST_TX_SRC:  if (debug_out_ready) state_next = ST_TX_HDR;
            ST_TX_HDR: begin
                if (debug_out_ready)
                    state_next = (resp_sub_q == SUB_RESP_READ_OK) ? ST_TX_DATA : ST_IDLE;
            end
            ST_TX_DATA: if (debug_out_ready) state_next = ST_IDLE;
            ST_DROP:    if (in_xfer && debug_in_last) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            resp_sub_q <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (load_src)   src_q      <= debug_in_data[9:0];
            if (load_hdr)   is_write_q <= (in_sub == SUB_REQ_WRITE);
            if (load_addr)  addr_q     <= debug_in_data;
            if (load_wdata) wdata_q    <= debug_in_data;
            if (access_done) begin
                resp_sub_q <= resp_sub_d;
                rdata_q    <= rdata_d;
            end
            tmo_cnt <= (state == ST_ACCESS) ? tmo_cnt + 10'd1 : 10'd0;
        end
    end

    always_comb begin
        debug_out_data  = 16'h0000;
        debug_out_valid = 1'b0;
        debug_out_first = 1'b0;
        debug_out_last  = 1'b0;
        case (state)
            ST_TX_DEST: begin
                debug_out_data  = {6'b0, src_q};
                debug_out_valid = 1'b1;
                debug_out_first = 1'b1;
            end
            ST_TX_SRC: begin
                debug_out_data  = {6'b0, id};
                debug_out_valid = 1'b1;
            end
            ST_TX_HDR: begin
                debug_out_data  = resp_header(resp_sub_q);
                debug_out_valid = 1'b1;
                debug_out_last  = (resp_sub_q != SUB_RESP_READ_OK);
            end
            ST_TX_DATA: begin
                debug_out_data  = rdata_q;
                debug_out_valid = 1'b1;
                debug_out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with rst keeps ready low while reset is held, high right after release.
    assign debug_in_ready = rst && (state == ST_IDLE || state == ST_RX_SRC ||
                                    state == ST_RX_HDR || state == ST_RX_ADDR ||
                                    state == ST_RX_WDATA || state == ST_DROP);

    assign reg_request = (state == ST_ACCESS) && fwd;
    assign reg_write   = is_write_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign dbg_state   = state;

endmodule

// File: doc/osd_regaccess_endpoint.md
Name: osd_regaccess_endpoint

Overview:
Module-side endpoint of the debug ring: receives register-access request packets on the router's local_out side and returns response packets on local_in. Decodes read/write requests, serves built-in identification registers locally, forwards other addresses to the host module over a simple register bus, and bounds that access with a timeout. One instance per debug module, attached to one ring port.

Parameters:
MOD_ID, 16'h0000, value returned at address 0x0000
MOD_VERSION, 16'h0000, value returned at address 0x0001
MOD_VENDOR, 16'h0001, value returned at address 0x0002
TIMEOUT, 255, max cycles waiting for reg_ack/reg_err before responding with an error (1..1023)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
id  in  10  this endpoint's ring address
debug_in_data  in  16  request word from ring
debug_in_valid  in  1  request word valid
debug_in_first  in  1  first word of packet
debug_in_last  in  1  last word of packet
debug_in_ready  out  1  endpoint accepts request word
debug_out_data  out  16  response word to ring
debug_out_valid  out  1  response word valid
debug_out_first  out  1  first word of response
debug_out_last  out  1  last word of response
debug_out_ready  in  1  ring accepts response word
reg_request  out  1  module register access in progress
reg_write  out  1  1 = write, 0 = read
reg_addr  out  16  register address
reg_wdata  out  16  write data
reg_ack  in  1  access completed successfully
reg_err  in  1  access failed
reg_rdata  in  16  read data, valid with reg_ack

Behaviour:
- Word transfer occurs when valid & ready are both high at the clk edge; a producer holds data/first/last stable while valid & !ready.
- Packet format: w0 dest[9:0], w1 src[9:0], w2 header (type[15:14], subtype[13:10], rest 0), w3 address, w4 write data (writes only). type 2'b00 = REG.
- Subtypes: REQ_READ=0 (4 words), REQ_WRITE=1 (5 words), RESP_READ_OK=8, RESP_READ_ERR=9, RESP_WRITE_OK=10, RESP_WRITE_ERR=11.
- FSM: IDLE -> RX_SRC -> RX_HDR -> RX_ADDR -> [RX_WDATA] -> ACCESS -> TX_DEST -> TX_SRC -> TX_HDR -> [TX_DATA] -> IDLE; DROP drains to last then IDLE.
- IDLE accepts only a word with first=1; a word with first=0 is consumed and ignored.
- Drop (silently, no response) when: dest != id; type != 0 or subtype not 0/1; last seen before expected final word (go IDLE immediately); last not set on expected final word (enter DROP, consume until last).
- debug_in_ready = 1 in IDLE, RX_*, DROP; 0 in ACCESS and TX_*.
- ACCESS, address 0x0000..0x0002: built-in, one cycle; reads return parameter, writes respond RESP_WRITE_ERR (read-only).
- ACCESS, 0x0003..0x01FF: respond *_ERR, one cycle, no bus activity.
- ACCESS, >= 0x0200: reg_request=1 with reg_write/reg_addr/reg_wdata stable from the cycle after the last request word until a cycle where reg_ack or reg_err is sampled high (reg_err wins if both); reg_request drops the next cycle. reg_rdata captured on reg_ack.
- Timeout: 10-bit counter cleared on ACCESS entry, incremented per waiting cycle; at count == TIMEOUT, drop reg_request, respond *_ERR; a late ack is ignored.
- Response: w0 = request src, w1 = id, w2 = response header, w3 = read data (RESP_READ_OK only). debug_out_first on w0, debug_out_last on final word. debug_out_valid rises in the cycle after ACCESS completes.
- Latency, built-in read with ready held high: last request word at edge N, ACCESS in cycle N+1, w0 valid in cycle N+2, w3 in cycle N+5.
- Backpressure: each TX state holds until debug_out_ready; no new request accepted until the response is fully sent.
- Reset (rst=0, any time): state IDLE, all outputs 0 except debug_in_ready = 0 during reset and 1 in the first cycle after release; an in-flight packet or bus access is abandoned and reg_request deasserts asynchronously.

Decomposition:
- Package osd_regaccess_pkg: type/subtype localparams, header field positions, built-in address constants, first-forwarded address 0x0200, FSM state enum.
- No sub-module. Single FSM plus address/data/src capture registers and timeout counter.

Test Plan:
- Read 0x0000, MOD_ID=16'hABCD, id=5, src=3 -> response 0x0003, 0x0005, hdr subtype 8, 0xABCD; w0 valid 2 cycles after request last.
- Write 0x0210=0x1234, reg_ack after 3 cycles -> reg_request high exactly 4 cycles with addr/wdata stable; response subtype 10, 3 words.
- Read 0x0300, reg_ack never -> reg_request falls after TIMEOUT=8 cycles; response subtype 9; ack pulse afterwards produces no output.
- Malformed: dest=6 with id=5; REQ_READ with last on w2; REQ_READ with 6 words -> no response, no reg_request, next valid request answered normally.
- debug_out_ready toggling 1/0 each cycle during response -> data/first/last stable while stalled; debug_in_ready held 0 until response last accepted.
- rst pulled low during reg_request -> reg_request and debug_out_valid fall immediately; after release, a new read 0x0001 gets a normal RESP_READ_OK.
